// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and constants for the AES block front end
package aes_pkg;

  typedef logic [1:0] asm_state_t;
  localparam asm_state_t ST_FILL  = 2'd0;
  localparam asm_state_t ST_FULL  = 2'd1;
  localparam asm_state_t ST_EXTRA = 2'd2;

  localparam int PAD_ZERO  = 0;
  localparam int PAD_PKCS7 = 1;

  typedef logic [15:0][7:0] aes_block_t;

endpackage

// File: rtl/block_pad.sv
// rtl/block_pad.sv - replaces words at and beyond count with the pad word
module block_pad
  import aes_pkg::*;
#(
  parameter int                WORD_W    = 8,
  parameter int                WORDS     = 16,
  parameter int                CNT_W     = 5,
  parameter int                PAD_MODE  = PAD_ZERO,
  parameter logic [WORD_W-1:0] PAD_VALUE = '0
) (
  input  logic [WORDS-1:0][WORD_W-1:0] blk_in,
  input  logic [CNT_W-1:0]             count_in,
  input  logic                         pad_en_in,
  output logic [WORDS-1:0][WORD_W-1:0] blk_out
);

  logic [WORD_W-1:0] pad_word;

  always_comb begin
    pad_word = (PAD_MODE == PAD_PKCS7) ? WORD_W'(WORDS - int'(count_in)) : PAD_VALUE;
    for (int k = 0; k < WORDS; k++) begin
      blk_out[k] = (pad_en_in && (k >= int'(count_in))) ? pad_word : blk_in[k];
    end
  end

endmodule

// File: rtl/block_assembler.sv
// rtl/block_assembler.sv - packs a word stream into padded, tagged fixed-size blocks
module block_assembler
  import aes_pkg::*;
#(
  parameter int                WORD_W    = 8,
  parameter int                WORDS     = 16,
  parameter int                PAD_MODE  = PAD_ZERO,
  parameter logic [WORD_W-1:0] PAD_VALUE = '0,
  localparam int               CNT_W     = $clog2(WORDS + 1),
  localparam int               IDX_W     = $clog2(WORDS)
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic [WORD_W-1:0]            data_in,
  input  logic                         valid_in,
  input  logic                         last_in,
  output logic                         ready_out,
  output logic [WORDS-1:0][WORD_W-1:0] block_out,
  output logic [CNT_W-1:0]             count_out,
  output logic                         last_out,
  output logic                         valid_out,
  input  logic                         ready_in
);

  typedef logic [WORDS-1:0][WORD_W-1:0] blk_t;

  asm_state_t       state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  blk_t             buf_q, buf_d;
  blk_t             out_blk_q, out_blk_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_last_q, out_last_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
  logic             pend_last_q, pend_last_d;
  logic             pend_extra_q, pend_extra_d;
  logic             live_q, live_d;

  blk_t             asm_blk, pad_blk;
  logic [CNT_W-1:0] pad_cnt;
  logic             pad_en;
  logic             accept, at_end, complete, slot_free, need_extra;

  assign ready_out  = live_q && (state_q == ST_FILL);
  assign accept     = valid_in && ready_out;
  assign at_end     = (index_q == IDX_W'(WORDS - 1));
  assign complete   = accept && (at_end || last_in);
  assign need_extra = (PAD_MODE == PAD_PKCS7) && last_in && at_end;
  assign slot_free  = !valid_q || ready_in;

  // One pad unit serves both the final partial block and the all-pad EXTRA block.
  always_comb begin
    asm_blk          = buf_q;
    asm_blk[index_q] = data_in;
    pad_cnt          = (state_q == ST_EXTRA) ? '0 : CNT_W'(index_q) + CNT_W'(1);
    pad_en           = (state_q == ST_EXTRA) || last_in;
  end

  block_pad #(
    .WORD_W   (WORD_W),
    .WORDS    (WORDS),
    .CNT_W    (CNT_W),
    .PAD_MODE (PAD_MODE),
    .PAD_VALUE(PAD_VALUE)
  ) u_pad (
    .blk_in   ((state_q == ST_EXTRA) ? buf_q : asm_blk),
    .count_in (pad_cnt),
    .pad_en_in(pad_en),
    .blk_out  (pad_blk)
  );

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    buf_d        = buf_q;
    out_blk_d    = out_blk_q;
    out_cnt_d    = out_cnt_q;
    out_last_d   = out_last_q;
    valid_d      = valid_q && !ready_in;
    pend_cnt_d   = pend_cnt_q;
    pend_last_d  = pend_last_q;
    pend_extra_d = pend_extra_q;
    live_d       = 1'b1;

    case (state_q)
      ST_FILL: begin
        if (accept) begin
          buf_d   = asm_blk;
          index_d = index_q + IDX_W'(1);
          if (complete) begin
            index_d = '0;
            if (slot_free) begin
              out_blk_d  = pad_blk;
              out_cnt_d  = pad_cnt;
              out_last_d = last_in && !need_extra;
              valid_d    = 1'b1;
              state_d    = need_extra ? ST_EXTRA : ST_FILL;
            end else begin
              // Park the finished block in the buffer until the output slot frees.
              buf_d        = pad_blk;
              pend_cnt_d   = pad_cnt;
              pend_last_d  = last_in && !need_extra;
              pend_extra_d = need_extra;
              state_d      = ST_FULL;
            end
          end
        end
      end
      ST_FULL: begin
        if (slot_free) begin
          out_blk_d  = buf_q;
          out_cnt_d  = pend_cnt_q;
          out_last_d = pend_last_q;
          valid_d    = 1'b1;
          state_d    = pend_extra_q ? ST_EXTRA : ST_FILL;
        end
      end
      ST_EXTRA: begin
        if (slot_free) begin
          out_blk_d  = pad_blk;
          out_cnt_d  = '0;
          out_last_d = 1'b1;
          valid_d    = 1'b1;
          state_d    = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_FILL;
      index_q      <= '0;
      buf_q        <= '0;
      out_blk_q    <= '0;
      out_cnt_q    <= '0;
      out_last_q   <= 1'b0;
      valid_q      <= 1'b0;
      pend_cnt_q   <= '0;
      pend_last_q  <= 1'b0;
      pend_extra_q <= 1'b0;
      live_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      buf_q        <= buf_d;
      out_blk_q    <= out_blk_d;
      out_cnt_q    <= out_cnt_d;
      out_last_q   <= out_last_d;
      valid_q      <= valid_d;
      pend_cnt_q   <= pend_cnt_d;
      pend_last_q  <= pend_last_d;
      pend_extra_q <= pend_extra_d;
      live_q       <= live_d;
    end
  end

  assign block_out = out_blk_q;
  assign count_out = out_cnt_q;
  assign last_out  = out_last_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_block_assembler.sv
// tb/tb_block_assembler.sv - scoreboard bench over three block_assembler configurations
module tb_block_assembler;

  typedef logic [511:0] v_t;
  typedef struct {
    logic [511:0] blk;
    logic [31:0]  cnt;
    logic         last;
  } exp_t;

  localparam int          NW [3] = '{16, 16, 4};
  localparam int          WW [3] = '{8, 8, 32};
  localparam int          PM [3] = '{0, 1, 0};
  localparam logic [31:0] PV [3] = '{32'h5A, 32'h0, 32'hCAFEF00D};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  int          sel = 0;
  logic [31:0] data_bus = '0;
  logic        valid_bus = 1'b0;
  logic        last_bus = 1'b0;
  logic        rdy_bus = 1'b1;
  logic        rand_rdy = 1'b0;
  logic        rnd_bit = 1'b1;
  logic        rdy_sel;

  logic [15:0][7:0]  b0, b1;
  logic [3:0][31:0]  b2;
  logic [4:0]        c0, c1;
  logic [2:0]        c2;
  v_t                ob [3];
  logic [31:0]       oc [3];
  logic              ol [3];
  logic              ov [3];
  logic              oro [3];
  logic              ori [3];
  logic              vi [3];

  int   n_tests = 0;
  int   n_fail = 0;
  exp_t q0[$], q1[$], q2[$];
  logic [31:0] msg[$];

  v_t          hb [3];
  logic [31:0] hc [3];
  logic        hl [3];
  logic        hv [3] = '{1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  assign rdy_sel = rand_rdy ? rnd_bit : rdy_bus;
  assign ob[0] = {384'd0, b0};
  assign ob[1] = {384'd0, b1};
  assign ob[2] = {384'd0, b2};
  assign oc[0] = {27'd0, c0};
  assign oc[1] = {27'd0, c1};
  assign oc[2] = {29'd0, c2};
  assign ori[0] = (sel == 0) ? rdy_sel : 1'b1;
  assign ori[1] = (sel == 1) ? rdy_sel : 1'b1;
  assign ori[2] = (sel == 2) ? rdy_sel : 1'b1;
  assign vi[0] = valid_bus && (sel == 0);
  assign vi[1] = valid_bus && (sel == 1);
  assign vi[2] = valid_bus && (sel == 2);

  block_assembler #(.WORD_W(8), .WORDS(16), .PAD_MODE(0), .PAD_VALUE(8'h5A)) u0 (
    .clk_in(clk), .rst_n_in(rst_n), .data_in(data_bus[7:0]), .valid_in(vi[0]),
    .last_in(last_bus), .ready_out(oro[0]), .block_out(b0), .count_out(c0),
    .last_out(ol[0]), .valid_out(ov[0]), .ready_in(ori[0]));

  block_assembler #(.WORD_W(8), .WORDS(16), .PAD_MODE(1), .PAD_VALUE(8'h00)) u1 (
    .clk_in(clk), .rst_n_in(rst_n), .data_in(data_bus[7:0]), .valid_in(vi[1]),
    .last_in(last_bus), .ready_out(oro[1]), .block_out(b1), .count_out(c1),
    .last_out(ol[1]), .valid_out(ov[1]), .ready_in(ori[1]));

  block_assembler #(.WORD_W(32), .WORDS(4), .PAD_MODE(0), .PAD_VALUE(32'hCAFEF00D)) u2 (
    .clk_in(clk), .rst_n_in(rst_n), .data_in(data_bus), .valid_in(vi[2]),
    .last_in(last_bus), .ready_out(oro[2]), .block_out(b2), .count_out(c2),
    .last_out(ol[2]), .valid_out(ov[2]), .ready_in(ori[2]));

  task automatic check(input string tag, input v_t got, input v_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push(input int k, input exp_t e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Reference packer: chops msg into NW-word chunks, pads the tail, adds the PKCS#7 extra block.
  task automatic model(input int k);
    exp_t        e;
    int          n, nw, ww, cnt;
    logic [31:0] v;
    n  = msg.size();
    nw = NW[k];
    ww = WW[k];
    for (int i = 0; i < n; i += nw) begin
      cnt   = (n - i < nw) ? n - i : nw;
      e.blk = '0;
      for (int j = 0; j < nw; j++) begin
        if (j < cnt) v = msg[i + j];
        else         v = (PM[k] == 1) ? 32'(nw - cnt) : PV[k];
        for (int b = 0; b < ww; b++) e.blk[j * ww + b] = v[b];
      end
      e.cnt  = 32'(cnt);
      e.last = (i + nw >= n) && !(PM[k] == 1 && cnt == nw);
      push(k, e);
    end
    if (PM[k] == 1 && (n % nw) == 0) begin
      e.blk = '0;
      for (int j = 0; j < nw; j++)
        for (int b = 0; b < ww; b++) e.blk[j * ww + b] = v_t'(nw) >> b;
      e.cnt  = 32'd0;
      e.last = 1'b1;
      push(k, e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (rst_n && hv[k]) begin
        check($sformatf("hold_valid%0d", k), v_t'(ov[k]), v_t'(1));
        check($sformatf("hold_blk%0d", k), ob[k], hb[k]);
        check($sformatf("hold_cnt%0d", k), v_t'(oc[k]), v_t'(hc[k]));
        check($sformatf("hold_last%0d", k), v_t'(ol[k]), v_t'(hl[k]));
      end
      if (rst_n && ov[k] && ori[k]) begin
        if (qsize(k) == 0) begin
          check($sformatf("unexpected_blk%0d", k), v_t'(1), v_t'(0));
        end else begin
          case (k)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
          endcase
          check($sformatf("blk%0d", k), ob[k], e.blk);
          check($sformatf("cnt%0d", k), v_t'(oc[k]), v_t'(e.cnt));
          check($sformatf("last%0d", k), v_t'(ol[k]), v_t'(e.last));
        end
      end
      hv[k] <= rst_n && ov[k] && !ori[k];
      hb[k] <= ob[k];
      hc[k] <= oc[k];
      hl[k] <= ol[k];
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_word(input int k, input logic [31:0] d, input logic l, input bit gaps);
    bit acc;
    acc = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    sel       = k;
    data_bus  = d;
    last_bus  = l;
    valid_bus = 1'b1;
    for (int t = 0; t < 300 && !acc; t++) begin
      @(negedge clk);
      acc = oro[k];
      @(posedge clk);
      #1;
    end
    valid_bus = 1'b0;
    last_bus  = 1'b0;
    if (!acc) check("send_timeout", v_t'(0), v_t'(1));
  endtask

  task automatic load_msg(input int k, input int n, input logic [31:0] base, input bit rnd);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(rnd ? $urandom() : base + 32'(i));
    model(k);
  endtask

  task automatic send_msg(input int k, input int n, input logic [31:0] base, input bit rnd);
    load_msg(k, n, base, rnd);
    for (int i = 0; i < n; i++) send_word(k, msg[i], i == n - 1, rnd);
  endtask

  task automatic drain(input int k);
    for (int t = 0; t < 400 && qsize(k) != 0; t++) begin @(posedge clk); #1; end
    check($sformatf("drain%0d", k), v_t'(qsize(k)), v_t'(0));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #11;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_valid%0d", k), v_t'(ov[k]), v_t'(0));
      check($sformatf("rst_ready%0d", k), v_t'(oro[k]), v_t'(0));
      check($sformatf("rst_cnt%0d", k), v_t'(oc[k]), v_t'(0));
      check($sformatf("rst_blk%0d", k), ob[k], v_t'(0));
    end
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check($sformatf("live_ready%0d", k), v_t'(oro[k]), v_t'(1));

    // Full 16-word message, constant padding, one-cycle output latency.
    load_msg(0, 16, 32'h0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      send_word(0, msg[i], i == 15, 1'b0);
      if (i == 14) check("early_valid", v_t'(ov[0]), v_t'(0));
    end
    check("latency_valid", v_t'(ov[0]), v_t'(1));
    drain(0);

    // Short PKCS#7 message.
    send_msg(1, 5, 32'hA0, 1'b0);
    drain(1);

    // Full PKCS#7 message needs an extra all-pad block; input stalls until it loads.
    load_msg(1, 16, 32'h30, 1'b0);
    for (int i = 0; i < 16; i++) send_word(1, msg[i], i == 15, 1'b0);
    check("extra_ready_low", v_t'(oro[1]), v_t'(0));
    check("extra_valid_a", v_t'(ov[1]), v_t'(1));
    @(posedge clk);
    #1;
    check("extra_ready_back", v_t'(oro[1]), v_t'(1));
    check("extra_valid_b", v_t'(ov[1]), v_t'(1));
    drain(1);

    // 48 words with downstream stalled once the first block appears.
    fork
      send_msg(0, 48, 32'h60, 1'b0);
      begin
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
          @(posedge clk);
          #1;
          seen = ov[0];
        end
        check("stall_first_valid", v_t'(seen), v_t'(1));
        rdy_bus = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("stall_ready_low", v_t'(oro[0]), v_t'(0));
        rdy_bus = 1'b1;
        check("b2b_valid0", v_t'(ov[0]), v_t'(1));
        @(posedge clk);
        #1;
        check("b2b_valid1", v_t'(ov[0]), v_t'(1));
      end
    join
    drain(0);

    // Asynchronous reset with one block held and a partial block in progress.
    rdy_bus = 1'b0;
    for (int i = 0; i < 23; i++) send_word(1, 32'hEE, 1'b0, 1'b0);
    check("pre_rst_valid", v_t'(ov[1]), v_t'(1));
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_valid", v_t'(ov[1]), v_t'(0));
    check("async_rst_ready", v_t'(oro[1]), v_t'(0));
    check("async_rst_cnt", v_t'(oc[1]), v_t'(0));
    rdy_bus = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    check("rel_ready_low", v_t'(oro[1]), v_t'(0));
    @(posedge clk);
    #1;
    check("rel_ready_high", v_t'(oro[1]), v_t'(1));
    send_msg(1, 16, 32'h40, 1'b0);
    drain(1);

    // Random messages with random gaps and random downstream backpressure.
    rand_rdy = 1'b1;
    for (int m = 0; m < 10; m++) send_msg(2, $urandom_range(1, 11), 32'h0, 1'b1);
    drain(2);
    rand_rdy = 1'b0;

    for (int k = 0; k < 3; k++) check($sformatf("left%0d", k), v_t'(qsize(k)), v_t'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d expected 0", 1);
    $fatal(1, "timeout");
  end

endmodule
